// File: rtl/if_fetch.sv
// Fetch stage / PC generator: drives the instruction SRAM and the {ce, pc} bundle to decode.
// Optional fetched-instruction counter enabled by defining IF_FETCH_CNT_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          IF_TO_ID_WD = 33,
    parameter int          BR_WD       = 33,
    parameter int          STALL_WD    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [31:0]            fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_HOLD_BR
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_reg, pc_n;
    logic [31:0] pend_addr, pend_n;
    logic        ce_reg, ce_n;
    logic [31:0] next_pc;
    logic        fire;
    logic        br_e;
    logic [31:0] br_addr;
    logic        stop;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign stop    = stall[0];

    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (state == S_HOLD_BR) begin
            next_pc = pend_addr;
        end else if (br_e) begin
            next_pc = br_addr;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_reg;
        ce_n    = ce_reg;
        pend_n  = pend_addr;
        fire    = 1'b0;
        if (!stop) begin
            // any state leaves for RUN and fetches next_pc when the stall clears
            pc_n    = next_pc;
            ce_n    = 1'b1;
            fire    = 1'b1;
            state_n = S_RUN;
        end else begin
            unique case (state)
                S_BOOT: state_n = S_BOOT;
                S_RUN, S_HOLD, S_HOLD_BR: begin
                    if (br_e) begin
                        pend_n  = br_addr;
                        state_n = S_HOLD_BR;
                    end else if (state != S_HOLD_BR) begin
                        state_n = S_HOLD;
                    end
                end
                default: state_n = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_BOOT;
            pc_reg    <= RESET_PC - 32'd4;
            ce_reg    <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            state     <= state_n;
            pc_reg    <= pc_n;
            ce_reg    <= ce_n;
            pend_addr <= pend_n;
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 32'h0;
        end else if (fire) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign fetch_cnt = cnt;
    logic unused_sink;
    assign unused_sink = ^stall[STALL_WD-1:1];
`else
    assign fetch_cnt = 32'h0;
    logic unused_sink;
    assign unused_sink = ^{stall[STALL_WD-1:1], fire};
`endif

    assign if_to_id_bus    = {ce_reg, pc_reg};
    assign inst_sram_en    = ce_reg;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'h0;

endmodule
